// File: rtl/doom_pixel_writer.sv
// Pixel writer: FIFO-buffers palette-indexed pixels, converts them through a 256-entry RGB565 palette
// and issues single Avalon-MM writes to the VGA pixel buffer. Optional colour key: DOOM_PIXEL_COLORKEY_EN.
module doom_pixel_writer #(
  parameter logic [31:0] FB_BASE    = 32'h0800_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          SCREEN_W   = 320,
  parameter int          SCREEN_H   = 200,
  parameter logic [7:0]  KEY_INDEX  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pal_write,
  input  logic [7:0]  pal_index,
  input  logic [23:0] pal_rgb,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [8:0]  px_x,
  input  logic [7:0]  px_y,
  input  logic [7:0]  px_index,
  output logic [31:0] vga_address,
  output logic        vga_write,
  output logic [15:0] vga_writedata,
  input  logic        vga_waitrequest,
  output logic        busy
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  SW_C    = 9'(SCREEN_W);
  localparam logic [8:0]  SH_C    = 9'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITE} state_t;

  state_t        r_state;
  logic [24:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic [15:0]   r_palRam [256];
  logic [15:0]   r_palData;
  logic [8:0]    r_x;
  logic [7:0]    r_y;

  logic          w_accept;
  logic          w_inRange;
  logic          w_keyed;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [24:0]   w_head;
  logic [AW:0]   w_countNext;
  logic          w_unused;

  // Off-screen and colour-keyed pixels still complete the handshake; they are simply not stored.
  assign w_accept  = px_valid && px_ready;
  assign w_inRange = (px_x < SW_C) && ({1'b0, px_y} < SH_C);
`ifdef DOOM_PIXEL_COLORKEY_EN
  assign w_keyed  = (px_index == KEY_INDEX);
  assign w_unused = ^{pal_rgb[18:16], pal_rgb[9:8], pal_rgb[2:0]};
`else
  assign w_keyed  = 1'b0;
  assign w_unused = ^{pal_rgb[18:16], pal_rgb[9:8], pal_rgb[2:0], (px_index == KEY_INDEX)};
`endif
  assign w_push      = w_accept && w_inRange && !w_keyed;
  assign w_empty     = (r_count == '0);
  assign w_head      = r_fifo[r_rdPtr];
  assign w_pop       = !w_empty && ((r_state == S_IDLE) ||
                                    ((r_state == S_WRITE) && !vga_waitrequest));
  assign w_countNext = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign px_ready = !r_full && !reset;
  assign busy     = !w_empty || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= {px_x, px_y, px_index};
    end
  end

  // Palette keeps its contents through reset; a same-cycle write and read returns the old entry.
  always_ff @(posedge clk) begin
    if (pal_write) begin
      r_palRam[pal_index] <= {pal_rgb[23:19], pal_rgb[15:10], pal_rgb[7:3]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_palData <= r_palRam[w_head[7:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      vga_write     <= 1'b0;
      vga_address   <= '0;
      vga_writedata <= '0;
      r_x           <= '0;
      r_y           <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_x     <= w_head[24:16];
            r_y     <= w_head[15:8];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          vga_address   <= FB_BASE + {14'd0, r_y, r_x, 1'b0};
          vga_writedata <= r_palData;
          vga_write     <= 1'b1;
          r_state       <= S_WRITE;
        end
        S_WRITE: begin
          // Write drops for a cycle even back-to-back so the slave never sees a duplicate transfer.
          if (!vga_waitrequest) begin
            vga_write <= 1'b0;
            if (w_pop) begin
              r_x     <= w_head[24:16];
              r_y     <= w_head[15:8];
              r_state <= S_LOOKUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          vga_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/doom_pixel_writer.md
Name: doom_pixel_writer

Overview:
- Downstream stage of the DOOM FPGA command engine (doom_fpga).
- Accepts palette-indexed pixels (x, y, 8-bit index) from the patch/column drawer through a valid/ready stream, buffers them in a FIFO and converts each through a 256-entry palette to RGB565.
- Issues single 16-bit Avalon-MM writes into the DE1 VGA pixel buffer.
- Also owns palette storage, loaded by the engine's PALETTE state.

Parameters:
- FB_BASE, 32'h0800_0000, byte base address of the VGA pixel buffer.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, 2..64.
- SCREEN_W, 320, pixel columns; x >= SCREEN_W is dropped.
- SCREEN_H, 200, pixel rows; y >= SCREEN_H is dropped.
- KEY_INDEX, 8'hFF, colour-key index (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pal_write  in  1  write one palette entry this cycle.
- pal_index  in  8  palette entry to write.
- pal_rgb  in  24  RGB888 colour {r,g,b}.
- px_valid  in  1  pixel offered.
- px_ready  out  1  FIFO can accept.
- px_x  in  9  column.
- px_y  in  8  row.
- px_index  in  8  palette index.
- vga_address  out  32  Avalon byte address.
- vga_write  out  1  Avalon write request.
- vga_writedata  out  16  RGB565 pixel.
- vga_waitrequest  in  1  slave stall.
- busy  out  1  FIFO non-empty or write pending.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; it is sampled only at the rising edge of clk.
- Reset values: vga_write=0, vga_address=0, vga_writedata=0, busy=0, FIFO empty, state IDLE. px_ready=0 while reset is high and 1 in the first cycle after. Palette RAM is not cleared.
- Reset mid-operation: an in-flight write is abandoned and FIFO contents are discarded.
- Accept: a pixel is accepted when px_valid && px_ready. px_ready = !fifo_full. px_valid with px_ready=0 is ignored and must be held by the source.
- Range check at accept: x >= SCREEN_W or y >= SCREEN_H is consumed (handshake completes) but not enqueued.
- FIFO: FIFO_DEPTH entries of {x,y,index}. Push and pop in the same cycle when full are allowed only if the pop occurs; px_ready reflects the registered full flag, not same-cycle pops.
- State machine:
  - IDLE: if FIFO non-empty, pop the entry, present index to the palette RAM, go to LOOKUP.
  - LOOKUP: register colour and address, assert vga_write, go to WRITE.
  - WRITE: hold address, data and vga_write=1 while vga_waitrequest=1. The first cycle with vga_waitrequest=0 completes the transfer. Then, if FIFO non-empty, pop and go to LOOKUP (back-to-back); else drop vga_write and go to IDLE.
- Latency: pixel accepted in cycle T into an empty, idle block → vga_write=1 in cycle T+3. Steady-state throughput with waitrequest low is 1 pixel per 2 cycles.
- Address: FB_BASE + y*1024 + x*2, computed as FB_BASE + {y, x[8:0], 1'b0} zero-extended to 32 bits; row stride is 512 pixels.
- Colour: RGB565 = {r[7:3], g[7:2], b[7:3]}.
- Palette RAM: 256 x 16 (RGB565 stored), 1-cycle read. Writes convert on entry. A same-cycle write and read of the same index returns the old data. A palette write affects only lookups started in later cycles. pal_write is accepted in any state, including during reset.
- busy = fifo non-empty or state != IDLE. The engine holds hps_waitrequest until busy=0.

Optional Feature:
- Macro: DOOM_PIXEL_COLORKEY_EN.
- Defined: pixels whose px_index == KEY_INDEX are consumed at accept and never enqueued, so no VGA write occurs.
- Undefined: KEY_INDEX is ignored and every in-range pixel is written.

Test Plan:
- Reset, then pal_write index 8'h05 = 24'hFF8040; pixel x=3, y=2, index=5 accepted at T → vga_write=1 at T+3, vga_address=32'h0800_0806, vga_writedata=16'hFC08; waitrequest=0 → vga_write=0 at T+4, busy=0 at T+4.
- vga_waitrequest=1 for 5 cycles on the first write → address and data held stable for all 5 cycles; exactly one write completes; FIFO keeps accepting.
- Stream 20 pixels with waitrequest held 1 (FIFO_DEPTH=16) → px_ready falls after 16 enqueued plus 1 popped. Release waitrequest → all 20 writes occur in order with correct addresses.
- Pixel x=320, y=0 and pixel x=0, y=200 → both handshakes complete, no vga_write, busy stays 0.
- Palette rewrite of index 5 to 24'h000000 while a pixel using index 5 is in WRITE → in-flight data stays 16'hFC08; the next pixel with index 5 writes 16'h0000.
- With DOOM_PIXEL_COLORKEY_EN, pixel index 8'hFF → no write; without the macro → write issued using palette entry 255.
